clz32_iter: RTL and testbench

//  Iterative 32-bit count-leading-zeros unit with valid/ready handshakes on both sides.

---
 rtl/clz_pkg.sv | 16 +
 rtl/clz_step.sv | 34 +++
 rtl/is_zero32.sv | 12 +
 rtl/clz32_iter.sv | 104 ++++++++++
 tb/tb_clz32_iter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/clz_pkg.sv
// Shared types and sizes for the iterative count-leading-zeros unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clz_pkg;

   localparam int CLZ_W     = 32;   // operand width
   localparam int CLZ_CW    = 6;    // count width, holds 0..32
   localparam int CLZ_STEPS = 5;    // halving steps: 16, 8, 4, 2, 1

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } clz_state_t;

endpackage

// File: rtl/clz_step.sv
// One binary-search step: tests whether the top 2^step bits of the window are zero.
// Latency: combinational.
// Backpressure: none.
// Ports: window/step in; hit (top bits zero), window_nxt (window shifted past them), add (bits skipped).
module clz_step
   import clz_pkg::*;
(
   input  logic [CLZ_W-1:0]  window,
   input  logic [2:0]        step,
   output logic              hit,
   output logic [CLZ_W-1:0]  window_nxt,
   output logic [CLZ_CW-1:0] add
);

   logic [CLZ_W-1:0]  mask;
   logic [CLZ_CW-1:0] n;

   always_comb begin
      n    = '0;
      mask = '0;
      case (step)
         3'd4:    begin n = 6'd16; mask = 32'hFFFF_0000; end
         3'd3:    begin n = 6'd8;  mask = 32'hFF00_0000; end
         3'd2:    begin n = 6'd4;  mask = 32'hF000_0000; end
         3'd1:    begin n = 6'd2;  mask = 32'hC000_0000; end
         // step 0; codes 5..7 never occur
         default: begin n = 6'd1;  mask = 32'h8000_0000; end
      endcase
      hit        = (window & mask) == '0;
      add        = hit ? n : '0;
      window_nxt = hit ? (window << n) : window;
   end

endmodule

// File: rtl/is_zero32.sv
// All-zero detect on a 32-bit word; shared cell also used by the datapath zero flag.
// Latency: combinational.
// Backpressure: none.
// Ports: data (32-bit word in), zero (1 when data is all zeros).
module is_zero32 (
   input  logic [31:0] data,
   output logic        zero
);

   assign zero = ~|data;

endmodule

// File: rtl/clz32_iter.sv
// Iterative 32-bit count-leading-zeros, one halving step per clock, valid/ready on both sides.
// Latency: result valid 5 edges after accept (1 edge for a zero operand when ZERO_FAST=1).
// Backpressure: in_ready only in IDLE; result and outputs held in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data operand side;
//        out_valid/out_ready/out_count/out_zero result side.
module clz32_iter
   import clz_pkg::*;
#(
   parameter bit ZERO_FAST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CLZ_W-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CLZ_CW-1:0] out_count,
   output logic              out_zero
);

   clz_state_t        state, state_nxt;
   logic [CLZ_W-1:0]  window;
   logic [CLZ_CW-1:0] cnt;
   logic [2:0]        step;
   logic              zflag;

   logic              in_zero;
   logic              hit;
   logic [CLZ_W-1:0]  window_nxt;
   logic [CLZ_CW-1:0] add;

   is_zero32 u_zero (
      .data (in_data),
      .zero (in_zero)
   );

   clz_step u_step (
      .window     (window),
      .step       (step),
      .hit        (hit),
      .window_nxt (window_nxt),
      .add        (add)
   );

   assign in_ready = (state == IDLE);

   // A zero operand is flagged at accept; with ZERO_FAST the first search
   // cycle short-circuits straight to DONE, so the result appears one edge later.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)                                state_nxt = SEARCH;
         SEARCH:  if ((ZERO_FAST && zflag) || step == 3'd0)    state_nxt = DONE;
         DONE:    if (out_ready)                               state_nxt = IDLE;
         default:                                              state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         window    <= '0;
         cnt       <= '0;
         step      <= '0;
         zflag     <= 1'b0;
         out_valid <= 1'b0;
         out_count <= '0;
         out_zero  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  window <= in_data;
                  cnt    <= '0;
                  step   <= 3'(CLZ_STEPS - 1);
                  zflag  <= in_zero;
               end
            end
            SEARCH: begin
               if (hit) begin
                  cnt    <= cnt + add;
                  window <= window_nxt;
               end
               if (state_nxt == DONE) begin
                  // add is zero on a miss, so cnt+add is the final count either way;
                  // a zero operand searches to 31 and is overridden to 32 here.
                  out_valid <= 1'b1;
                  out_zero  <= zflag;
                  out_count <= zflag ? 6'd32 : (cnt + add);
               end else begin
                  step <= step - 3'd1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clz32_iter.sv
// Self-checking bench for clz32_iter: directed latency/backpressure/reset cases plus
// random operands scored against a bit-scan reference model through an expected-result queue.
module tb_clz32_iter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [31:0] in_data;
   logic [5:0]  out_count;

   logic        in_valid0, in_ready0, out_valid0, out_ready0, out_zero0;
   logic [31:0] in_data0;
   logic [5:0]  out_count0;

   int          n_vec  = 0;
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [6:0]  exp_q[$];
   logic [6:0]  e;
   bit          rand_ordy = 1'b0;
   bit          hold_prev = 1'b0;
   logic [5:0]  prev_count;
   logic        prev_zero;
   int          k;

   clz32_iter #(.ZERO_FAST(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_zero(out_zero)
   );

   clz32_iter #(.ZERO_FAST(1'b0)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_count(out_count0), .out_zero(out_zero0)
   );

   // Reference: scan from the MSB for the first set bit. Returns {zero, count}.
   function automatic logic [6:0] ref_clz(input logic [31:0] x);
      for (int i = 31; i >= 0; i--)
         if (x[i]) return {1'b0, 6'(31 - i)};
      return {1'b1, 6'd32};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [31:0] d, input bit push);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin tick(); n++; end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      if (push) exp_q.push_back(ref_clz(d));
      n_vec++;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin tick(); cyc++; end
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
      chk("drain", exp_q.size(), 0);
      tick();
      out_ready = 1'b0;
   endtask

   // Monitor: results are taken on the edge that follows a negedge with valid&&ready.
   always @(negedge clk) begin
      if (out_valid) begin
         if (hold_prev) begin
            chk("hold_count", out_count, prev_count);
            chk("hold_zero", out_zero, prev_zero);
         end
         chk("zero_vs_count", out_zero, out_count == 6'd32);
         if (out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("count", out_count, e[5:0]);
               chk("zero", out_zero, e[6]);
            end
            hold_prev = 1'b0;
         end else begin
            hold_prev  = 1'b1;
            prev_count = out_count;
            prev_zero  = out_zero;
         end
      end else begin
         hold_prev = 1'b0;
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_in_ready0", in_ready0, 1);

      // MSB set: count 0 after exactly five search cycles
      send(32'h8000_0000, 1'b1);
      wait_valid(k);
      chk("lat_msb", k, 5);
      drain();

      // LSB only and mid-word bit
      send(32'h0000_0001, 1'b1);
      drain();
      send(32'h0001_0000, 1'b1);
      drain();

      // zero operand, fast path
      send(32'h0000_0000, 1'b1);
      wait_valid(k);
      chk("lat_zero_fast", k, 1);
      drain();

      // zero operand and a non-zero one on the ZERO_FAST=0 instance
      for (int t = 0; t < 2; t++) begin
         in_valid0 = 1'b1;
         in_data0  = (t == 0) ? 32'h0 : 32'h0001_0000;
         tick();
         in_valid0 = 1'b0;
         k = 0;
         while (!out_valid0 && k < 20) begin tick(); k++; end
         chk("lat_slow", k, 5);
         chk("slow_count", out_count0, (t == 0) ? 32 : 15);
         chk("slow_zero", out_zero0, (t == 0) ? 1 : 0);
         out_ready0 = 1'b1;
         tick();
         out_ready0 = 1'b0;
         chk("slow_release", out_valid0, 0);
      end

      // backpressure: four cycles held in DONE
      send(32'h00F0_0000, 1'b1);
      wait_valid(k);
      chk("lat_bp", k, 5);
      repeat (4) begin
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_idle_ready", in_ready, 1);
      chk("bp_idle_valid", out_valid, 0);
      out_ready = 1'b0;

      // in_valid kept high with changing data while busy
      send(32'h0000_0F00, 1'b1);
      in_valid = 1'b1;
      k = 0;
      while (!out_valid && k < 20) begin
         in_data = $urandom();
         tick();
         k++;
      end
      in_valid = 1'b0;
      drain();
      repeat (8) tick();
      chk("no_extra_accept", out_valid, 0);

      // reset during the third search cycle drops the operation
      send(32'h1234_5678, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_count", out_count, 0);
      repeat (8) begin
         tick();
         chk("midrst_quiet", out_valid, 0);
      end
      send(32'h0000_00FF, 1'b1);
      drain();

      // random operands with random consumer stalls
      rand_ordy = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] d;
         repeat ($urandom_range(0, 2)) tick();
         d = $urandom() >> $urandom_range(0, 32);
         if ($urandom_range(0, 15) == 0) d = '0;
         send(d, 1'b1);
      end
      rand_ordy = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
